// File: rtl/avaliador_palpite_pkg.sv
// Shared types and defaults for the guess evaluator (avaliador_palpite).
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package avaliador_pkg;

    localparam int WIDTH_DEF    = 6;
    localparam int MAX_TENT_DEF = 8;
    localparam int TENT_W_DEF   = 4;

    // Round control states; the encoding is fixed so debug probes read stable values.
    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        ESPERA   = 3'd1,
        COMPARA  = 3'd2,
        REGISTRA = 3'd3,
        FIM      = 3'd4
    } estado_t;

    // One-hot result of a single guess.
    typedef struct packed {
        logic menor;
        logic maior;
        logic igual;
    } flags_t;

    // Equal wins over greater, greater wins over less. No flag at all
    // decodes to all zeros, which the round treats as a miss.
    function automatic flags_t decodifica(input logic alb, input logic agb, input logic aeb);
        flags_t f;
        f = '0;
        if (aeb) begin
            f.igual = 1'b1;
        end else if (agb) begin
            f.maior = 1'b1;
        end else if (alb) begin
            f.menor = 1'b1;
        end
        return f;
    endfunction

    // True when exactly one comparator output is asserted.
    function automatic logic eh_one_hot(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/avaliador_palpite_if.sv
// Game-control side bundle of the guess evaluator: round start, guess handshake, results.
// Latency: none (wires only).
// Backpressure: a guess is taken only on an edge where pronto and palpite_valido are both high.
interface avaliador_palpite_if #(
    parameter int WIDTH  = 6,
    parameter int TENT_W = 4
);
    logic              iniciar;
    logic [WIDTH-1:0]  segredo;
    logic [WIDTH-1:0]  palpite;
    logic              palpite_valido;
    logic              pronto;
    logic              resultado_valido;
    logic              menor;
    logic              maior;
    logic              igual;
    logic [TENT_W-1:0] tentativas;
    logic              acertou;
    logic              esgotou;
    logic              erro_cmp;

    // Game control unit drives the round.
    modport master (
        output iniciar, segredo, palpite, palpite_valido,
        input  pronto, resultado_valido, menor, maior, igual,
        input  tentativas, acertou, esgotou, erro_cmp
    );

    // The evaluator answers.
    modport slave (
        input  iniciar, segredo, palpite, palpite_valido,
        output pronto, resultado_valido, menor, maior, igual,
        output tentativas, acertou, esgotou, erro_cmp
    );
endinterface

// File: rtl/avaliador_palpite_uc.sv
// Control unit of the guess evaluator: sequences accept, compare, publish and end-of-round.
// Latency: guess accepted at edge N, publish strobe during the cycle after edge N+1, ready again after edge N+2.
// Backpressure: pronto only in ESPERA; iniciar beats palpite_valido there and is ignored while a guess is in flight.
module avaliador_palpite_uc
    import avaliador_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic iniciar,
    input  logic palpite_valido,
    input  logic igual_q,
    input  logic tent_no_max,
    output logic pronto,
    output logic carrega,
    output logic aceita,
    output logic captura,
    output logic publica,
    output logic fim_acerto,
    output logic fim_esgota
);

    estado_t estado_q, estado_d;

    // State register; reset returns to INICIAL and drops any guess in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state and per-state strobes for the datapath.
    always_comb begin
        estado_d   = estado_q;
        pronto     = 1'b0;
        carrega    = 1'b0;
        aceita     = 1'b0;
        captura    = 1'b0;
        publica    = 1'b0;
        fim_acerto = 1'b0;
        fim_esgota = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    carrega  = 1'b1;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                pronto = 1'b1;
                if (iniciar) begin
                    carrega  = 1'b1;
                    estado_d = ESPERA;
                end else if (palpite_valido) begin
                    aceita   = 1'b1;
                    estado_d = COMPARA;
                end
            end
            COMPARA: begin
                // The comparator is combinational; its outputs are settled by the end of this cycle.
                captura  = 1'b1;
                estado_d = REGISTRA;
            end
            REGISTRA: begin
                publica = 1'b1;
                if (igual_q) begin
                    fim_acerto = 1'b1;
                    estado_d   = FIM;
                end else if (tent_no_max) begin
                    fim_esgota = 1'b1;
                    estado_d   = FIM;
                end else begin
                    estado_d = ESPERA;
                end
            end
            FIM: begin
                if (iniciar) begin
                    carrega  = 1'b1;
                    estado_d = ESPERA;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

endmodule

// File: rtl/avaliador_palpite.sv
// Guess evaluator: registers secret/guess for an external 6-bit comparator and publishes the decoded result.
// Latency: guess accepted at edge N, resultado_valido in cycle N+2, pronto again in cycle N+3 if the round continues.
// Backpressure: valid/ready on palpite (pronto only while waiting); optional AVALIADOR_CHECK_EN adds a sticky erro_cmp.
module avaliador_palpite
    import avaliador_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_TENT = MAX_TENT_DEF,
    parameter int TENT_W   = TENT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    avaliador_palpite_if.slave jogo,
    output logic [WIDTH-1:0]  cmp_a,
    output logic [WIDTH-1:0]  cmp_b,
    output logic              cmp_albi,
    output logic              cmp_agbi,
    output logic              cmp_aebi,
    input  logic              alb,
    input  logic              agb,
    input  logic              aeb
);

    logic carrega, aceita, captura, publica, fim_acerto, fim_esgota;
    logic tent_no_max;

    logic [WIDTH-1:0]  cmp_a_q, cmp_a_d;
    logic [WIDTH-1:0]  cmp_b_q, cmp_b_d;
    logic [TENT_W-1:0] tent_q, tent_d;
    flags_t            flags_q, flags_d;
    logic              acertou_q, acertou_d;
    logic              esgotou_q, esgotou_d;

    assign tent_no_max = (tent_q == TENT_W'(MAX_TENT));

    avaliador_palpite_uc u_uc (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (jogo.iniciar),
        .palpite_valido (jogo.palpite_valido),
        .igual_q        (flags_q.igual),
        .tent_no_max    (tent_no_max),
        .pronto         (jogo.pronto),
        .carrega        (carrega),
        .aceita         (aceita),
        .captura        (captura),
        .publica        (publica),
        .fim_acerto     (fim_acerto),
        .fim_esgota     (fim_esgota)
    );

    // Datapath next values: secret on round start, guess and count on accept, flags at end of compare.
    always_comb begin
        cmp_a_d   = cmp_a_q;
        cmp_b_d   = cmp_b_q;
        tent_d    = tent_q;
        flags_d   = flags_q;
        acertou_d = acertou_q;
        esgotou_d = esgotou_q;
        if (carrega) begin
            cmp_b_d   = jogo.segredo;
            tent_d    = '0;
            flags_d   = '0;
            acertou_d = 1'b0;
            esgotou_d = 1'b0;
        end
        if (aceita) begin
            cmp_a_d = jogo.palpite;
            // Saturate so the count can never wrap past the attempt limit.
            if (!tent_no_max) begin
                tent_d = tent_q + TENT_W'(1);
            end
        end
        if (captura) begin
            flags_d = decodifica(alb, agb, aeb);
        end
        if (fim_acerto) begin
            acertou_d = 1'b1;
        end
        if (fim_esgota) begin
            esgotou_d = 1'b1;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            tent_q    <= '0;
            flags_q   <= '0;
            acertou_q <= 1'b0;
            esgotou_q <= 1'b0;
        end else begin
            cmp_a_q   <= cmp_a_d;
            cmp_b_q   <= cmp_b_d;
            tent_q    <= tent_d;
            flags_q   <= flags_d;
            acertou_q <= acertou_d;
            esgotou_q <= esgotou_d;
        end
    end

`ifdef AVALIADOR_CHECK_EN
    logic [2:0] bruto_q, bruto_d;
    logic       erro_q, erro_d;

    // Keep the raw comparator outputs and flag any non one-hot set while publishing; sticky until a new round.
    always_comb begin
        bruto_d = bruto_q;
        erro_d  = erro_q;
        if (captura) begin
            bruto_d = {alb, agb, aeb};
        end
        if (carrega) begin
            erro_d = 1'b0;
        end else if (publica && !eh_one_hot(bruto_q)) begin
            erro_d = 1'b1;
        end
    end

    // Consistency-check registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bruto_q <= '0;
            erro_q  <= 1'b0;
        end else begin
            bruto_q <= bruto_d;
            erro_q  <= erro_d;
        end
    end

    assign jogo.erro_cmp = erro_q;
`else
    assign jogo.erro_cmp = 1'b0;
`endif

    assign cmp_a    = cmp_a_q;
    assign cmp_b    = cmp_b_q;
    // Cascade inputs make a standalone 6-bit comparison: "equal so far".
    assign cmp_albi = 1'b0;
    assign cmp_agbi = 1'b0;
    assign cmp_aebi = 1'b1;

    assign jogo.resultado_valido = publica;
    assign jogo.menor            = flags_q.menor;
    assign jogo.maior            = flags_q.maior;
    assign jogo.igual            = flags_q.igual;
    assign jogo.tentativas       = tent_q;
    assign jogo.acertou          = acertou_q;
    assign jogo.esgotou          = esgotou_q;

endmodule

// File: tb/tb_avaliador_palpite.sv
// Bench for avaliador_palpite: directed round scenarios plus randomized traffic against a round-level model.
// Latency: the model expects each result one cycle after the compare cycle.
// Backpressure: guesses are offered only when pronto is seen; ignored offers are also exercised.
module tb_avaliador_palpite;
    import avaliador_pkg::*;

    localparam int W  = 6;
    localparam int MT = 8;
    localparam int TW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    avaliador_palpite_if #(.WIDTH(W), .TENT_W(TW)) jogo ();

    logic [W-1:0] cmp_a, cmp_b;
    logic cmp_albi, cmp_agbi, cmp_aebi;
    logic alb, agb, aeb;
    logic stub_bad = 1'b0;

    // External comparator, with a faulty mode asserting both less and greater.
    assign alb = stub_bad ? 1'b1 : (cmp_a < cmp_b);
    assign agb = stub_bad ? 1'b1 : (cmp_a > cmp_b);
    assign aeb = stub_bad ? 1'b0 : (cmp_a == cmp_b);

    avaliador_palpite #(.WIDTH(W), .MAX_TENT(MT), .TENT_W(TW)) dut (
        .clock    (clock),
        .reset    (reset),
        .jogo     (jogo),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .cmp_albi (cmp_albi),
        .cmp_agbi (cmp_agbi),
        .cmp_aebi (cmp_aebi),
        .alb      (alb),
        .agb      (agb),
        .aeb      (aeb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- round-level model ----------------
    // m_since: -1 no guess in flight, 0 just accepted, 1 result being shown.
    int         m_since  = -1;
    logic       m_active = 1'b0;
    logic       m_over   = 1'b0;
    logic [W-1:0] m_sec  = '0;
    logic [W-1:0] m_gss  = '0;
    int         m_cnt    = 0;
    logic       e_menor = 1'b0, e_maior = 1'b0, e_igual = 1'b0;
    logic       m_ac = 1'b0, m_es = 1'b0, m_err = 1'b0, m_bad = 1'b0;

    always @(posedge clock) begin
        logic lt, gt, eq;
        if (!reset) begin
            m_since = -1; m_active = 1'b0; m_over = 1'b0;
            m_sec = '0; m_gss = '0; m_cnt = 0;
            e_menor = 1'b0; e_maior = 1'b0; e_igual = 1'b0;
            m_ac = 1'b0; m_es = 1'b0; m_err = 1'b0; m_bad = 1'b0;
        end else if (m_since == 0) begin
            lt = stub_bad || (m_gss < m_sec);
            gt = stub_bad || (m_gss > m_sec);
            eq = !stub_bad && (m_gss == m_sec);
            e_igual = eq;
            e_maior = !eq && gt;
            e_menor = !eq && !gt && lt;
            m_bad   = (int'(lt) + int'(gt) + int'(eq)) != 1;
            m_since = 1;
        end else if (m_since == 1) begin
            if (e_igual) begin
                m_ac = 1'b1; m_over = 1'b1;
            end else if (m_cnt == MT) begin
                m_es = 1'b1; m_over = 1'b1;
            end
`ifdef AVALIADOR_CHECK_EN
            if (m_bad) m_err = 1'b1;
`endif
            m_since = -1;
        end else if (jogo.iniciar) begin
            m_active = 1'b1; m_over = 1'b0;
            m_sec = jogo.segredo; m_cnt = 0;
            e_menor = 1'b0; e_maior = 1'b0; e_igual = 1'b0;
            m_ac = 1'b0; m_es = 1'b0; m_err = 1'b0;
        end else if (m_active && !m_over && jogo.palpite_valido) begin
            m_gss = jogo.palpite;
            m_cnt++;
            m_since = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        chk("pronto", 32'(jogo.pronto), 32'(m_active && !m_over && (m_since < 0)));
        chk("resultado_valido", 32'(jogo.resultado_valido), 32'(m_since == 1));
        chk("cmp_a", 32'(cmp_a), 32'(m_gss));
        chk("cmp_b", 32'(cmp_b), 32'(m_sec));
        chk("tentativas", 32'(jogo.tentativas), 32'(m_cnt));
        chk("menor", 32'(jogo.menor), 32'(e_menor));
        chk("maior", 32'(jogo.maior), 32'(e_maior));
        chk("igual", 32'(jogo.igual), 32'(e_igual));
        chk("acertou", 32'(jogo.acertou), 32'(m_ac));
        chk("esgotou", 32'(jogo.esgotou), 32'(m_es));
        chk("erro_cmp", 32'(jogo.erro_cmp), 32'(m_err));
        chk("cascata", 32'({cmp_albi, cmp_agbi, cmp_aebi}), 32'(3'b001));
    end

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start_round(input logic [W-1:0] s);
        jogo.segredo = s;
        jogo.iniciar = 1'b1;
        tick();
        jogo.iniciar = 1'b0;
    endtask

    // Offers one guess, returns latency (negedges after accept until the result strobe) and flags {menor,maior,igual}.
    task automatic guess(input logic [W-1:0] g, output int lat, output logic [2:0] fl);
        int k;
        k = 0;
        lat = -1;
        fl = '0;
        while (!jogo.pronto && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL pronto_timeout actual=0 required=1");
        end
        jogo.palpite = g;
        jogo.palpite_valido = 1'b1;
        tick();
        jogo.palpite_valido = 1'b0;
        k = 1;
        while (!jogo.resultado_valido && k < 8) begin
            tick();
            k++;
        end
        lat = k;
        fl = {jogo.menor, jogo.maior, jogo.igual};
        tick();
    endtask

    int lat;
    logic [2:0] fl;

    initial begin
        jogo.iniciar = 1'b0;
        jogo.segredo = '0;
        jogo.palpite = '0;
        jogo.palpite_valido = 1'b0;

        // 1. reset then start with secret 37
        reset = 1'b0;
        tick(); tick();
        chk("rst_pronto", 32'(jogo.pronto), 32'd0);
        chk("rst_tent", 32'(jogo.tentativas), 32'd0);
        chk("rst_cmp_ab", 32'({cmp_a, cmp_b}), 32'd0);
        chk("rst_flags", 32'({jogo.menor, jogo.maior, jogo.igual, jogo.acertou, jogo.esgotou}), 32'd0);
        reset = 1'b1;
        tick();
        start_round(6'd37);
        chk("t1_pronto", 32'(jogo.pronto), 32'd1);
        chk("t1_cmp_b", 32'(cmp_b), 32'd37);
        chk("t1_tent", 32'(jogo.tentativas), 32'd0);

        // 2. low, high, hit
        guess(6'd10, lat, fl);
        chk("t2_lat1", 32'(lat), 32'd2);
        chk("t2_menor", 32'(fl), 32'(3'b100));
        guess(6'd50, lat, fl);
        chk("t2_lat2", 32'(lat), 32'd2);
        chk("t2_maior", 32'(fl), 32'(3'b010));
        guess(6'd37, lat, fl);
        chk("t2_lat3", 32'(lat), 32'd2);
        chk("t2_igual", 32'(fl), 32'(3'b001));
        chk("t2_tent", 32'(jogo.tentativas), 32'd3);
        chk("t2_acertou", 32'(jogo.acertou), 32'd1);
        chk("t2_pronto", 32'(jogo.pronto), 32'd0);
        chk("t2_model_cnt", 32'(m_cnt), 32'd3);

        // 3. exhaust attempts
        start_round(6'd63);
        for (int i = 0; i < MT; i++) guess(6'd0, lat, fl);
        chk("t3_esgotou", 32'(jogo.esgotou), 32'd1);
        chk("t3_acertou", 32'(jogo.acertou), 32'd0);
        chk("t3_tent", 32'(jogo.tentativas), 32'd8);
        chk("t3_model_es", 32'(m_es), 32'd1);
        jogo.palpite_valido = 1'b1;
        tick();
        jogo.palpite_valido = 1'b0;
        tick(); tick();
        chk("t3_ninth_tent", 32'(jogo.tentativas), 32'd8);
        chk("t3_ninth_pronto", 32'(jogo.pronto), 32'd0);

        // 4. boundaries
        start_round(6'd0);
        guess(6'd0, lat, fl);
        chk("t4_zero", 32'(fl), 32'(3'b001));
        start_round(6'd63);
        guess(6'd63, lat, fl);
        chk("t4_max", 32'(fl), 32'(3'b001));
        start_round(6'd20);
        for (int i = 0; i < MT - 1; i++) guess(6'd21, lat, fl);
        guess(6'd20, lat, fl);
        chk("t4_last_acertou", 32'(jogo.acertou), 32'd1);
        chk("t4_last_esgotou", 32'(jogo.esgotou), 32'd0);
        chk("t4_last_tent", 32'(jogo.tentativas), 32'd8);

        // 5. reset during compare, then iniciar during publish
        start_round(6'd5);
        jogo.palpite = 6'd9;
        jogo.palpite_valido = 1'b1;
        tick();
        jogo.palpite_valido = 1'b0;
        reset = 1'b0;
        tick();
        chk("t5_rv", 32'(jogo.resultado_valido), 32'd0);
        chk("t5_outs", 32'({jogo.pronto, jogo.tentativas, cmp_a, cmp_b}), 32'd0);
        reset = 1'b1;
        tick();
        chk("t5_rv2", 32'(jogo.resultado_valido), 32'd0);
        chk("t5_idle", 32'(jogo.pronto), 32'd0);
        start_round(6'd5);
        jogo.palpite = 6'd9;
        jogo.palpite_valido = 1'b1;
        tick();
        jogo.palpite_valido = 1'b0;
        tick();
        chk("t5_in_publish", 32'(jogo.resultado_valido), 32'd1);
        jogo.segredo = 6'd40;
        jogo.iniciar = 1'b1;
        tick();
        jogo.iniciar = 1'b0;
        chk("t5_cmp_b_kept", 32'(cmp_b), 32'd5);
        chk("t5_tent_kept", 32'(jogo.tentativas), 32'd1);
        chk("t5_continue", 32'(jogo.pronto), 32'd1);

`ifdef AVALIADOR_CHECK_EN
        // 6. inconsistent comparator
        start_round(6'd10);
        stub_bad = 1'b1;
        guess(6'd3, lat, fl);
        stub_bad = 1'b0;
        chk("t6_maior", 32'(fl), 32'(3'b010));
        chk("t6_erro", 32'(jogo.erro_cmp), 32'd1);
        guess(6'd10, lat, fl);
        chk("t6_sticky", 32'(jogo.erro_cmp), 32'd1);
        start_round(6'd1);
        chk("t6_clear", 32'(jogo.erro_cmp), 32'd0);
`endif

        // Randomized traffic; the every-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] s;
            int r;
            r = $urandom_range(0, 99);
            s = (r < 10) ? 6'd0 : (r < 20) ? 6'd63 : W'($urandom_range(0, 63));
            jogo.segredo = s;
            jogo.iniciar = ($urandom_range(0, 99) < 4);
            jogo.palpite_valido = !jogo.iniciar && ($urandom_range(0, 99) < 45);
            jogo.palpite = ($urandom_range(0, 1) == 1) ? m_sec ^ W'($urandom_range(0, 3))
                                                       : W'($urandom_range(0, 63));
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1;
        jogo.iniciar = 1'b0;
        jogo.palpite_valido = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
